alu_arbiter_2ch: RTL and testbench



---
 rtl/alu_arbiter_2ch.sv | 126 ++++++++++++
 tb/tb_alu_arbiter_2ch.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_2ch.sv
// Two-channel round-robin arbiter in front of a shared 4-bit ALU: grant, latch operands, execute, report.
// Build option: define ALU_ARB_FIXED_PRIO_EN to give channel 0 fixed priority on ties instead of round-robin.

module alu_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [4:0] out
);
  always_comb begin
    out = '0;
    case (op)
      3'b000:  out = {1'b0, a} + {1'b0, b};
      3'b001:  out = {1'b0, a} - {1'b0, b};
      default: out = '0;
    endcase
  end
endmodule

module alu_arbiter_2ch (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [2:0] op0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [2:0] op1,
  output logic       done0,
  output logic       done1,
  output logic [4:0] result,
  output logic       err,
  output logic       busy,
  output logic       owner
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } alu_req_t;

  alu_req_t [1:0] ch;
  logic [1:0]     req;
  alu_req_t       lat;
  logic [1:0]     state;
  logic           last;
  logic           gnt;
  logic           err_flag;
  logic [4:0]     alu_out;

  assign req   = {req1, req0};
  assign ch[0] = '{a: a0, b: b0, op: op0};
  assign ch[1] = '{a: a1, b: b1, op: op1};

  // On a tie the channel that was not served last wins; a lone request always wins.
  always_comb begin
    gnt = req[1];
    if (&req) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = ~last;
`endif
    end
  end

  // The ALU only ever sees the latched operands, so requesters may change inputs after grant.
  alu_4bit u_alu (
    .a  (lat.a),
    .b  (lat.b),
    .op (lat.op),
    .out(alu_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      lat      <= '0;
      err_flag <= 1'b0;
      result   <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            lat   <= ch[gnt];
            owner <= gnt;
            last  <= gnt;
            busy  <= 1'b1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          result   <= alu_out;
          err_flag <= (lat.op[2:1] != 2'b00);
          state    <= S_DONE;
        end
        S_DONE: begin
          done0 <= ~owner;
          done1 <= owner;
          err   <= err_flag;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Directed bench for alu_arbiter_2ch: single ops, tie arbitration, bad opcode, mid-op reset, late operand change.
module tb_alu_arbiter_2ch;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] op0, op1;
  logic       done0, done1, err, busy, owner;
  logic [4:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_2ch dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .op0   (op0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .op1   (op1),
    .done0 (done0),
    .done1 (done1),
    .result(result),
    .err   (err),
    .busy  (busy),
    .owner (owner)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a done pulse, checking latency in negedges and the served outputs.
  task automatic wait_done(input string tag, input int exp_ch, input int exp_res,
                           input int exp_err, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done0 || done1) && n < 10);
    chk({tag, "_lat"},   n, exp_lat);
    chk({tag, "_done0"}, int'(done0), int'(exp_ch == 0));
    chk({tag, "_done1"}, int'(done1), int'(exp_ch == 1));
    chk({tag, "_res"},   int'(result), exp_res);
    chk({tag, "_err"},   int'(err), exp_err);
    chk({tag, "_owner"}, int'(owner), exp_ch);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_done", int'(done0 | done1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_res", int'(result), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Tie from reset: ch0 first, then alternation (or ch0 again with fixed priority).
    req0 = 1; a0 = 3; b0 = 2; op0 = 3'b000;
    req1 = 1; a1 = 9; b1 = 4; op1 = 3'b001;
    wait_done("tie1", 0, 5, 0, 3);
`ifdef ALU_ARB_FIXED_PRIO_EN
    wait_done("tie2", 0, 5, 0, 3);
`else
    wait_done("tie2", 1, 5, 0, 3);
`endif
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("tie_pulse", int'(done0 | done1), 0);
    @(negedge clk);
    chk("tie_idle", int'(busy), 0);

    // Single add on ch0.
    req0 = 1; a0 = 7; b0 = 5; op0 = 3'b000;
    @(negedge clk);
    req0 = 0;
    chk("add_busy", int'(busy), 1);
    chk("add_own", int'(owner), 0);
    wait_done("add", 0, 12, 0, 2);
    @(negedge clk);
    chk("add_pulse", int'(done0), 0);
    chk("add_hold", int'(result), 12);
    chk("add_nobusy", int'(busy), 0);

    // Single subtract on ch1.
    req1 = 1; a1 = 9; b1 = 4; op1 = 3'b001;
    @(negedge clk);
    req1 = 0;
    wait_done("sub", 1, 5, 0, 2);
    @(negedge clk);

    // Undefined opcode: completes with result 0 and err.
    req0 = 1; a0 = 15; b0 = 15; op0 = 3'b110;
    @(negedge clk);
    req0 = 0;
    wait_done("badop", 0, 0, 1, 2);
    @(negedge clk);
    chk("badop_errclr", int'(err), 0);

    // Operands changed after the grant edge are ignored.
    req0 = 1; a0 = 2; b0 = 1; op0 = 3'b000;
    @(negedge clk);
    req0 = 0; a0 = 14;
    wait_done("late", 0, 3, 0, 2);
    @(negedge clk);

    // Reset during EXEC of a ch1 request aborts it.
    req1 = 1; a1 = 4; b1 = 4; op1 = 3'b000;
    @(negedge clk);
    req1 = 0;
    chk("mid_busy_pre", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", int'(busy), 0);
    chk("mid_res", int'(result), 0);
    chk("mid_owner", int'(owner), 0);
    chk("mid_done", int'(done0 | done1), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (done0 || done1) seen++;
        if (i == 1) rst = 1'b0;
      end
      chk("mid_nodone", seen, 0);
    end
    req1 = 1;
    @(negedge clk);
    req1 = 0;
    wait_done("mid_retry", 1, 8, 0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
